// File: rtl/aeif_neuron_array_if.sv
// Control/data bundle for the AdEx neuron array: update controls and
// currents in, spike pulses, frame strobe and the selected membrane value out.
interface aeif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8
);
    localparam int SEL_W = $clog2(N_NEURONS);

    logic                       en;
    logic                       adapt_en;
    logic [N_NEURONS*WIDTH-1:0] current;
    logic [SEL_W-1:0]           state_sel;
    logic [N_NEURONS-1:0]       spike;
    logic [WIDTH-1:0]           state;
    logic                       frame_done;

    // Stimulus side: drives controls and currents, observes spikes and state.
    modport master (
        output en, adapt_en, current, state_sel,
        input  spike, state, frame_done
    );

    // Neuron array side.
    modport slave (
        input  en, adapt_en, current, state_sel,
        output spike, state, frame_done
    );
endinterface

// File: rtl/aeif_neuron_array.sv
// Time-multiplexed array of adaptive exponential integrate-and-fire neurons.
// One shared datapath updates neuron `ptr` per enabled cycle; membrane V,
// adaptation w and the refractory counter live in small register files.
module aeif_neuron_array #(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = 8,
    parameter int V_RESET     = 0,
    parameter int V_T         = 160,
    parameter int V_PEAK      = 240,
    parameter int LEAK_SHIFT  = 4,
    parameter int EXP_SHIFT   = 3,
    parameter int B_INC       = 16,
    parameter int TAU_W_SHIFT = 5,
    parameter int REFRAC      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aeif_neuron_array_if.slave   bus
);
    localparam int SEL_W = $clog2(N_NEURONS);
    localparam int CW    = WIDTH + 3;
    localparam int REF_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

    localparam logic [WIDTH-1:0] V_MAX    = '1;
    localparam logic [WIDTH-1:0] VT_W     = WIDTH'(V_T);
    localparam logic [WIDTH-1:0] VPEAK_W  = WIDTH'(V_PEAK);
    localparam logic [WIDTH-1:0] VRESET_W = WIDTH'(V_RESET);

    typedef logic signed [CW-1:0] acc_t;

    // Zero-extend an unsigned state value into the signed accumulator.
    function automatic acc_t ext(input logic [WIDTH-1:0] x);
        return acc_t'({{(CW - WIDTH){1'b0}}, x});
    endfunction

    logic [SEL_W-1:0]     ptr;
    logic [WIDTH-1:0]     v_mem   [N_NEURONS];
    logic [WIDTH-1:0]     w_mem   [N_NEURONS];
    logic [REF_W-1:0]     ref_mem [N_NEURONS];
    logic [WIDTH-1:0]     cur_in  [N_NEURONS];
    logic [N_NEURONS-1:0] spike_q;
    logic                 frame_q;

    logic [WIDTH-1:0] v_cur, w_cur, i_cur;
    logic [REF_W-1:0] ref_cur;
    logic [WIDTH-1:0] v_over, exp_step, vn, w_decay;
    logic [2:0]       k;
    logic [WIDTH:0]   w_bumped;
    acc_t             leak, exp_term, w_term, vn_raw;
    logic [WIDTH-1:0] v_next, w_next;
    logic [REF_W-1:0] ref_next;
    logic             fire;

    // Slice the flat current bus into one value per neuron.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            cur_in[i] = bus.current[i*WIDTH +: WIDTH];
        end
    end

    // Shared AdEx update for the neuron currently under the pointer.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        v_cur    = v_mem[ptr];
        w_cur    = w_mem[ptr];
        ref_cur  = ref_mem[ptr];
        i_cur    = cur_in[ptr];

        leak     = ext(v_cur >> LEAK_SHIFT);
        v_over   = v_cur - VT_W;
        exp_step = v_over >> EXP_SHIFT;
        k        = (exp_step > WIDTH'(7)) ? 3'd7 : exp_step[2:0];
        exp_term = (v_cur > VT_W) ? (acc_t'(1) << k) : '0;
        w_term   = bus.adapt_en ? ext(w_cur) : '0;
        vn_raw   = ext(v_cur) - leak + ext(i_cur) + exp_term - w_term;

        // Clamp the signed sum back into the unsigned membrane range.
        if (vn_raw[CW-1])           vn = '0;
        else if (vn_raw > ext(V_MAX)) vn = V_MAX;
        else                        vn = vn_raw[WIDTH-1:0];

        // Decay is applied first; the spike increment builds on the decayed value.
        w_decay  = w_cur - (w_cur >> TAU_W_SHIFT);
        w_bumped = {1'b0, w_decay} + (WIDTH+1)'(B_INC);

        fire     = 1'b0;
        v_next   = vn;
        w_next   = w_decay;
        ref_next = ref_cur;

        if (ref_cur != '0) begin
            // Refractory: membrane pinned, input ignored, no spike possible.
            v_next   = VRESET_W;
            ref_next = ref_cur - 1'b1;
        end else if (vn >= VPEAK_W) begin
            fire     = 1'b1;
            v_next   = VRESET_W;
            ref_next = REF_W'(REFRAC);
            if (bus.adapt_en) begin
                w_next = w_bumped[WIDTH] ? V_MAX : w_bumped[WIDTH-1:0];
            end
        end
    end

    // Write back the updated neuron, advance the pointer, register the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            spike_q <= '0;
            frame_q <= 1'b0;
            // NOTE: the state files are reset because a cleared array is part of the
            // block's observable behaviour; they are tiny flop arrays, not RAM macros.
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]   <= '0;
                w_mem[i]   <= '0;
                ref_mem[i] <= '0;
            end
        end else if (bus.en) begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            v_mem[ptr]   <= v_next;
            w_mem[ptr]   <= w_next;
            ref_mem[ptr] <= ref_next;
            ptr          <= ptr + 1'b1;
            spike_q      <= fire ? (N_NEURONS'(1) << ptr) : '0;
            frame_q      <= (ptr == SEL_W'(N_NEURONS - 1));
        end else begin
            spike_q <= '0;
            frame_q <= 1'b0;
        end
    end

    assign bus.spike      = spike_q;
    assign bus.frame_done = frame_q;
    assign bus.state      = v_mem[bus.state_sel];
endmodule

// File: tb/tb_aeif_neuron_array.sv
// Directed bench for aeif_neuron_array. A second instance with a large spike
// increment exercises the saturating adaptation path.
module tb_aeif_neuron_array;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    aeif_neuron_array_if #(.N_NEURONS(N), .WIDTH(W)) dut_if ();
    aeif_neuron_array_if #(.N_NEURONS(N), .WIDTH(W)) sat_if ();

    aeif_neuron_array #(.N_NEURONS(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    aeif_neuron_array #(.N_NEURONS(N), .WIDTH(W), .B_INC(200)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sat_if.slave)
    );

    always #5 clk = ~clk;

    // Membrane of neuron 0, current 20, no adaptation: one full period.
    int seq_na [17] = '{20, 39, 57, 74, 90, 105, 119, 132, 144, 155, 166, 177, 190, 207, 0, 0, 0};
    // Same with adaptation: after the spike w=16 cancels most of the input.
    int seq_ad [22] = '{20, 39, 57, 74, 90, 105, 119, 132, 144, 155, 166, 177, 190, 207,
                        0, 0, 0, 4, 8, 12, 16, 19};
    // Neuron 1, current 255, adaptation on: V after updates 1..13.
    int seq_n1 [13] = '{0, 0, 0, 239, 0, 0, 0, 224, 0, 0, 0, 210, 0};
    // Saturation instance, neuron 0, current 255: V after updates 1..10.
    int seq_sat [10] = '{0, 0, 0, 67, 135, 204, 0, 0, 0, 14};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dut_if.en = 1'b0; dut_if.adapt_en = 1'b0; dut_if.current = '0; dut_if.state_sel = '0;
        sat_if.en = 1'b0; sat_if.adapt_en = 1'b0; sat_if.current = '0; sat_if.state_sel = '0;
    endtask

    task automatic do_reset();
        dut_if.en = 1'b0;
        sat_if.en = 1'b0;
        tick();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();

        // Reset state.
        check("rst_spike", 32'(dut_if.spike), 0);
        check("rst_frame", 32'(dut_if.frame_done), 0);
        for (int s = 0; s < N; s++) begin
            dut_if.state_sel = 2'(s);
            #1;
            check("rst_state", 32'(dut_if.state), 0);
        end
        rst_n = 1'b1;
        dut_if.en = 1'b1;

        // Zero currents: silent array, frame strobe every 4 cycles.
        for (int t = 1; t <= 20; t++) begin
            tick();
            check("idle_spike", 32'(dut_if.spike), 0);
            check("idle_frame", 32'(dut_if.frame_done), (t % 4 == 0) ? 1 : 0);
        end
        for (int s = 0; s < N; s++) begin
            dut_if.state_sel = 2'(s);
            #1;
            check("idle_state", 32'(dut_if.state), 0);
        end

        // Neuron 2 at full current: fires, two refractory slots, fires again.
        do_reset();
        dut_if.current[2*W +: W] = 8'd255;
        dut_if.state_sel = 2'd2;
        dut_if.en = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            check("n2_spike", 32'(dut_if.spike), (t == 3 || t == 15) ? 4 : 0);
            check("n2_state", 32'(dut_if.state), 0);
        end

        // Neuron 0, current 20, no adaptation: exponential run-up, period 17 slots.
        do_reset();
        dut_if.current[0 +: W] = 8'd20;
        dut_if.en = 1'b1;
        for (int u = 1; u <= 32; u++) begin
            tick();
            check("n0_v", 32'(dut_if.state), seq_na[(u-1) % 17]);
            check("n0_spike", 32'(dut_if.spike), ((u-1) % 17 == 14) ? 1 : 0);
            repeat (3) tick();
        end

        // Same with adaptation: no second spike within 40 slots.
        do_reset();
        dut_if.current[0 +: W] = 8'd20;
        dut_if.adapt_en = 1'b1;
        dut_if.en = 1'b1;
        for (int u = 1; u <= 40; u++) begin
            tick();
            if (u <= 22) check("n0a_v", 32'(dut_if.state), seq_ad[u-1]);
            check("n0a_spike", 32'(dut_if.spike), (u == 15) ? 1 : 0);
            repeat (3) tick();
        end

        // Neuron 1 at full current with adaptation; saturation instance alongside.
        do_reset();
        dut_if.current[1*W +: W] = 8'd255;
        dut_if.adapt_en = 1'b1;
        dut_if.state_sel = 2'd1;
        sat_if.current[0 +: W] = 8'd255;
        sat_if.adapt_en = 1'b1;
        sat_if.state_sel = 2'd0;
        dut_if.en = 1'b1;
        sat_if.en = 1'b1;
        for (int t = 1; t <= 52; t++) begin
            tick();
            check("n1_spike", 32'(dut_if.spike),
                  (t == 2 || t == 18 || t == 34 || t == 50) ? 2 : 0);
            check("sat_spike", 32'(sat_if.spike), (t == 1 || t == 25) ? 1 : 0);
            if (t % 4 == 2) check("n1_v", 32'(dut_if.state), seq_n1[(t-2)/4]);
            if (t % 4 == 1 && (t-1)/4 < 10) check("sat_v", 32'(sat_if.state), seq_sat[(t-1)/4]);
        end

        // Enable hold mid-frame: everything frozen, resume from the same neuron.
        do_reset();
        dut_if.current[0 +: W] = 8'd20;
        dut_if.current[2*W +: W] = 8'd255;
        dut_if.en = 1'b1;
        tick();
        check("hold_pre_v0", 32'(dut_if.state), 20);
        tick();
        tick();
        check("hold_pre_spike", 32'(dut_if.spike), 4);
        dut_if.en = 1'b0;
        dut_if.current[0 +: W] = 8'd200;
        for (int h = 1; h <= 5; h++) begin
            tick();
            check("hold_spike", 32'(dut_if.spike), 0);
            check("hold_frame", 32'(dut_if.frame_done), 0);
            check("hold_v0", 32'(dut_if.state), 20);
        end
        dut_if.current[0 +: W] = 8'd20;
        dut_if.en = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            tick();
            check("resume_spike", 32'(dut_if.spike), (r == 12) ? 4 : 0);
            check("resume_frame", 32'(dut_if.frame_done), (r % 4 == 1) ? 1 : 0);
            if (r == 2)  check("resume_v0", 32'(dut_if.state), 39);
            if (r == 6)  check("resume_v0", 32'(dut_if.state), 57);
            if (r == 10) check("resume_v0", 32'(dut_if.state), 74);
        end

        // Asynchronous reset while neuron 3 is refractory.
        do_reset();
        dut_if.current[0 +: W] = 8'd20;
        dut_if.current[3*W +: W] = 8'd255;
        dut_if.en = 1'b1;
        tick();
        check("ar_pre_v0", 32'(dut_if.state), 20);
        repeat (3) tick();
        check("ar_pre_spike", 32'(dut_if.spike), 8);
        check("ar_pre_frame", 32'(dut_if.frame_done), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_spike", 32'(dut_if.spike), 0);
        check("ar_frame", 32'(dut_if.frame_done), 0);
        check("ar_state", 32'(dut_if.state), 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("ar_first_v0", 32'(dut_if.state), 20);
        check("ar_first_spike", 32'(dut_if.spike), 0);
        check("ar_first_frame", 32'(dut_if.frame_done), 0);
        tick();
        tick();
        tick();
        check("ar_n3_spike", 32'(dut_if.spike), 8);
        check("ar_n3_frame", 32'(dut_if.frame_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
